rgmii_rx_ctrl: RTL and testbench
================================

Name: rgmii_rx_ctrl

Overview:
- Sequences the raw DDR capture of an RGMII receive port (5-bit q1/q2 pairs: rxd[3:0] plus rx_ctl) into a GMII-style byte stream with a clock-enable strobe.
- Selects 1000 Mb/s (byte per clock) or 10/100 Mb/s (nibble assembly) decoding at runtime.
- Decodes RGMII in-band link status during inter-frame periods.
- Sits directly after the source-synchronous DDR input stage, in the recovered RX clock domain, ahead of the MAC RX path.

Parameters:
- STATUS_FILTER, 2, number of consecutive identical in-band status samples required before the status outputs update (1-15).

Ports:
- clk  input  1  RX logic clock (recovered RX clock from the DDR input stage).
- rst  input  1  synchronous, active-high reset.
- ddr_q1  input  5  rising-edge capture {rx_ctl, rxd[3:0]}.
- ddr_q2  input  5  falling-edge capture {rx_ctl, rxd[3:0]}.
- mii_select  input  1  1 = 10/100 nibble mode, 0 = 1000 byte mode; sampled only in IDLE.
- gmii_rxd  output  8  assembled receive byte.
- gmii_rx_dv  output  1  data valid, qualified by gmii_clk_en.
- gmii_rx_er  output  1  receive error, qualified by gmii_clk_en.
- gmii_clk_en  output  1  byte strobe; constant 1 in 1000 mode, one pulse per byte in 10/100 mode.
- link_up  output  1  in-band link status.
- link_speed  output  2  in-band speed: 00=10, 01=100, 10=1000, 11=reserved.
- full_duplex  output  1  in-band duplex status.
- status_valid  output  1  high once any filtered status has been accepted.
- nibble_misalign  output  1  one-cycle pulse when a frame ends on an odd nibble.

Behaviour:
- Reset values: gmii_rxd=0, gmii_rx_dv=0, gmii_rx_er=0, gmii_clk_en=0, link_up=0, link_speed=00, full_duplex=0, status_valid=0, nibble_misalign=0. State returns to IDLE and the filter counter is cleared.
- Per-cycle decode: dv = q1[4]; er = q1[4] ^ q2[4].
- Inter-frame condition: q1[4]=0 and q2[4]=0.
- Registered mode register mode_q: loaded from mii_select only while the state is IDLE. A change of mii_select mid-frame has no effect until the frame ends.
- State machine, states IDLE, BYTE, NIB_LO, NIB_HI:
  - IDLE: if dv=1 and mode_q=0, go to BYTE. If dv=1 and mode_q=1, capture q1[3:0] as the low nibble and go to NIB_HI. Otherwise stay.
  - BYTE (1000 mode): every cycle, gmii_rxd={q2[3:0],q1[3:0]}, gmii_rx_dv=dv, gmii_rx_er=er. All outputs are registered, latency 1 cycle. gmii_clk_en=1 in all states while mode_q=0 and not in reset. Return to IDLE when dv=0 and er=0.
  - NIB_HI (10/100 mode): gmii_rxd={q1[3:0], low_nibble}, gmii_rx_dv=1, gmii_rx_er=(er of either nibble), gmii_clk_en=1 for one cycle; go to NIB_LO. Byte latency is 1 cycle after the high nibble.
  - NIB_LO: if dv=1, capture the low nibble and go to NIB_HI. If dv=0, go to IDLE with no strobe.
- Frame ending in NIB_HI (dv drops on a high-nibble cycle): pulse nibble_misalign and gmii_clk_en once, with gmii_rx_dv=1, gmii_rx_er=1 and gmii_rxd={4'h0, low_nibble}; then go to IDLE.
- 10/100 mode outside bytes: gmii_clk_en=0 except on byte strobes. gmii_rx_dv and gmii_rx_er hold their last values between strobes and return to 0 on the strobe-less IDLE entry.
- In-band status, evaluated in every state whenever the inter-frame condition holds:
  - Candidate = q1[3:0] (bit0 link, bits2:1 speed, bit3 duplex).
  - Candidate equal to the previous candidate: counter increments, saturating at STATUS_FILTER.
  - Candidate different: counter reloads to 1.
  - Counter reaching STATUS_FILTER: link_up, link_speed and full_duplex load from the candidate; status_valid=1.
  - Samples where the condition does not hold leave the counter unchanged.
- Carrier extend / false carrier (dv=0, er=1) in BYTE: output gmii_rx_dv=0, gmii_rx_er=1 and stay in BYTE. No status update occurs.
- Reset mid-frame: the next cycle shows all outputs at reset values; the partial frame is discarded.

Decomposition:
- Package rgmii_pkg holds:
  - state enum rgmii_rx_state_t {IDLE, BYTE, NIB_LO, NIB_HI};
  - speed localparams SPEED_10=2'b00, SPEED_100=2'b01, SPEED_1000=2'b10;
  - bit-index constants for the 5-bit DDR word (CTL_BIT=4).
- Sub-module rgmii_inband_status: the filter counter plus status registers, parameterised by STATUS_FILTER.
- Main FSM and datapath stay in rgmii_rx_ctrl.

Test Plan:
- 1000 mode, frame bytes 0x55,0x55,0xD5,0xAB with q1={1,lo}, q2={1,hi} -> gmii_rxd shows the same sequence one cycle later, gmii_rx_dv=1, gmii_rx_er=0, gmii_clk_en=1 throughout.
- 10/100 mode, nibbles 5,5,5,5,5,D (dv=1), then dv=0 -> three strobes with bytes 0x55,0x55,0xD5; gmii_clk_en active on alternate cycles; no nibble_misalign.
- 10/100 mode, 3 nibbles A,B,C then dv=0 -> strobe 0xBA, then one strobe with rxd=0x0C, gmii_rx_er=1, and a nibble_misalign pulse.
- Inter-frame q1=q2=5'b0_1011, STATUS_FILTER=2 -> after the 2nd cycle: link_up=1, link_speed=01, full_duplex=1, status_valid=1. A single glitch sample 5'b0_0000 -> outputs unchanged.
- 1000 mode, one byte with q1[4]=1, q2[4]=0 -> gmii_rx_er=1, gmii_rx_dv=1. Then q1[4]=0, q2[4]=1 -> gmii_rx_dv=0, gmii_rx_er=1, state stays BYTE.
- Assert rst mid-frame in 10/100 mode; toggle mii_select mid-frame -> outputs at reset values the next cycle; a mode change applies only after IDLE is re-entered.

Source files
------------

// File: rtl/rgmii_pkg.sv
// Purpose: shared types and constants for the RGMII receive controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rgmii_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BYTE   = 2'd1,
        NIB_LO = 2'd2,
        NIB_HI = 2'd3
    } rgmii_rx_state_t;

    localparam logic [1:0] SPEED_10   = 2'b00;
    localparam logic [1:0] SPEED_100  = 2'b01;
    localparam logic [1:0] SPEED_1000 = 2'b10;

    // Bit positions inside the 5-bit {rx_ctl, rxd[3:0]} DDR capture word.
    localparam int CTL_BIT  = 4;
    localparam int DATA_MSB = 3;

endpackage

// File: rtl/rgmii_inband_status.sv
// Purpose: glitch-filters RGMII in-band status nibbles and holds link/speed/duplex.
// Latency: status registers update 1 cycle after the STATUS_FILTER-th matching sample.
// Backpressure: none; samples are consumed whenever sample_vld is high.
module rgmii_inband_status
    import rgmii_pkg::*;
#(
    parameter int STATUS_FILTER = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sample_vld,
    input  logic [DATA_MSB:0]   sample_dat,
    output logic                link_up,
    output logic [1:0]          link_speed,
    output logic                full_duplex,
    output logic                status_valid
);

    localparam logic [3:0] FILT = 4'(STATUS_FILTER);

    logic [3:0]        cnt_q,    cnt_d;
    logic [DATA_MSB:0] prev_q,   prev_d;
    logic              link_q,   link_d;
    logic [1:0]        speed_q,  speed_d;
    logic              duplex_q, duplex_d;
    logic              valid_q,  valid_d;

    // Count consecutive identical candidates; accept once the run reaches the filter depth.
    always_comb begin
        cnt_d    = cnt_q;
        prev_d   = prev_q;
        link_d   = link_q;
        speed_d  = speed_q;
        duplex_d = duplex_q;
        valid_d  = valid_q;
        if (sample_vld) begin
            // A zero count means no candidate seen yet, so the first sample always starts a run.
            if ((cnt_q != 4'd0) && (sample_dat == prev_q)) begin
                cnt_d = (cnt_q >= FILT) ? FILT : cnt_q + 4'd1;
            end else begin
                cnt_d = 4'd1;
            end
            prev_d = sample_dat;
            if (cnt_d == FILT) begin
                link_d   = sample_dat[0];
                speed_d  = sample_dat[2:1];
                duplex_d = sample_dat[3];
                valid_d  = 1'b1;
            end
        end
    end

    // Filter and status state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= 4'd0;
            prev_q   <= '0;
            link_q   <= 1'b0;
            speed_q  <= SPEED_10;
            duplex_q <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            prev_q   <= prev_d;
            link_q   <= link_d;
            speed_q  <= speed_d;
            duplex_q <= duplex_d;
            valid_q  <= valid_d;
        end
    end

    assign link_up      = link_q;
    assign link_speed   = speed_q;
    assign full_duplex  = duplex_q;
    assign status_valid = valid_q;

endmodule

// File: rtl/rgmii_rx_ctrl.sv
// Purpose: turns RGMII DDR q1/q2 captures into a GMII byte stream plus clock enable.
// Latency: 1 cycle per byte in 1000 mode; 1 cycle after the high nibble in 10/100 mode.
// Backpressure: none; the line rate cannot be stalled, every capture is consumed.
module rgmii_rx_ctrl
    import rgmii_pkg::*;
#(
    parameter int STATUS_FILTER = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] ddr_q1,
    input  logic [4:0] ddr_q2,
    input  logic       mii_select,
    output logic [7:0] gmii_rxd,
    output logic       gmii_rx_dv,
    output logic       gmii_rx_er,
    output logic       gmii_clk_en,
    output logic       link_up,
    output logic [1:0] link_speed,
    output logic       full_duplex,
    output logic       status_valid,
    output logic       nibble_misalign
);

    rgmii_rx_state_t state_q, state_d;
    logic            mode_q, mode_d;
    logic [3:0]      low_q, low_d;
    logic            low_er_q, low_er_d;
    logic [7:0]      rxd_q, rxd_d;
    logic            dv_q, dv_d;
    logic            er_q, er_d;
    logic            clk_en_q, clk_en_d;
    logic            misalign_q, misalign_d;

    logic            in_dv;
    logic            in_er;
    logic            inter_frame;
    logic [3:0]      q1_nib;
    logic [3:0]      q2_nib;

    assign in_dv       = ddr_q1[CTL_BIT];
    assign in_er       = ddr_q1[CTL_BIT] ^ ddr_q2[CTL_BIT];
    assign inter_frame = ~ddr_q1[CTL_BIT] & ~ddr_q2[CTL_BIT];
    assign q1_nib      = ddr_q1[DATA_MSB:0];
    assign q2_nib      = ddr_q2[DATA_MSB:0];

    // Next-state and output decode; outputs hold unless a state below overrides them.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        low_d      = low_q;
        low_er_d   = low_er_q;
        rxd_d      = rxd_q;
        dv_d       = dv_q;
        er_d       = er_q;
        clk_en_d   = ~mode_q;
        misalign_d = 1'b0;
        case (state_q)
            IDLE: begin
                // Mode only changes between frames so a frame is decoded consistently.
                mode_d = mii_select;
                if (!mode_q) begin
                    // 1000 mode passes every cycle through, so the SOF byte is not lost.
                    rxd_d = {q2_nib, q1_nib};
                    dv_d  = in_dv;
                    er_d  = in_er;
                    if (in_dv) state_d = BYTE;
                end else if (in_dv) begin
                    low_d    = q1_nib;
                    low_er_d = in_er;
                    state_d  = NIB_HI;
                end
            end
            BYTE: begin
                rxd_d = {q2_nib, q1_nib};
                dv_d  = in_dv;
                er_d  = in_er;
                // Carrier extend (dv=0, er=1) keeps the frame open.
                if (!in_dv && !in_er) state_d = IDLE;
            end
            NIB_HI: begin
                clk_en_d = 1'b1;
                dv_d     = 1'b1;
                if (in_dv) begin
                    rxd_d   = {q1_nib, low_q};
                    er_d    = low_er_q | in_er;
                    state_d = NIB_LO;
                end else begin
                    // Odd nibble count: flush the orphan nibble flagged as an error.
                    rxd_d      = {4'h0, low_q};
                    er_d       = 1'b1;
                    misalign_d = 1'b1;
                    state_d    = IDLE;
                end
            end
            NIB_LO: begin
                if (in_dv) begin
                    low_d    = q1_nib;
                    low_er_d = in_er;
                    state_d  = NIB_HI;
                end else begin
                    dv_d    = 1'b0;
                    er_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM, mode and registered GMII outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            mode_q     <= 1'b0;
            low_q      <= 4'h0;
            low_er_q   <= 1'b0;
            rxd_q      <= 8'h00;
            dv_q       <= 1'b0;
            er_q       <= 1'b0;
            clk_en_q   <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            low_q      <= low_d;
            low_er_q   <= low_er_d;
            rxd_q      <= rxd_d;
            dv_q       <= dv_d;
            er_q       <= er_d;
            clk_en_q   <= clk_en_d;
            misalign_q <= misalign_d;
        end
    end

    rgmii_inband_status #(
        .STATUS_FILTER (STATUS_FILTER)
    ) u_status (
        .clk          (clk),
        .rst          (rst),
        .sample_vld   (inter_frame),
        .sample_dat   (q1_nib),
        .link_up      (link_up),
        .link_speed   (link_speed),
        .full_duplex  (full_duplex),
        .status_valid (status_valid)
    );

    assign gmii_rxd        = rxd_q;
    assign gmii_rx_dv      = dv_q;
    assign gmii_rx_er      = er_q;
    assign gmii_clk_en     = clk_en_q;
    assign nibble_misalign = misalign_q;

endmodule

// File: tb/tb_rgmii_rx_ctrl.sv
// Purpose: directed self-checking bench for rgmii_rx_ctrl.
// Latency: inputs applied #1 after a rising edge, outputs checked #1 after the next one.
// Backpressure: n/a.
module tb_rgmii_rx_ctrl;
    import rgmii_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] ddr_q1;
    logic [4:0] ddr_q2;
    logic       mii_select;
    logic [7:0] gmii_rxd;
    logic       gmii_rx_dv;
    logic       gmii_rx_er;
    logic       gmii_clk_en;
    logic       link_up;
    logic [1:0] link_speed;
    logic       full_duplex;
    logic       status_valid;
    logic       nibble_misalign;

    int checks = 0;
    int errors = 0;

    localparam logic [4:0] IDLE_W = 5'b0_1011;

    rgmii_rx_ctrl #(.STATUS_FILTER(2)) dut (
        .clk             (clk),
        .rst             (rst),
        .ddr_q1          (ddr_q1),
        .ddr_q2          (ddr_q2),
        .mii_select      (mii_select),
        .gmii_rxd        (gmii_rxd),
        .gmii_rx_dv      (gmii_rx_dv),
        .gmii_rx_er      (gmii_rx_er),
        .gmii_clk_en     (gmii_clk_en),
        .link_up         (link_up),
        .link_speed      (link_speed),
        .full_duplex     (full_duplex),
        .status_valid    (status_valid),
        .nibble_misalign (nibble_misalign)
    );

    always #5 clk = ~clk;

    task automatic step(input logic [4:0] q1, input logic [4:0] q2);
        ddr_q1 = q1;
        ddr_q2 = q2;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] all_out();
        return 32'({gmii_rxd, gmii_rx_dv, gmii_rx_er, gmii_clk_en, link_up,
                    link_speed, full_duplex, status_valid, nibble_misalign});
    endfunction

    logic [7:0] bytes_1g [4];
    logic [3:0] nibs     [6];
    logic       strobe   [6];
    logic [7:0] nib_byte [6];

    initial begin
        bytes_1g = '{8'h55, 8'h55, 8'hD5, 8'hAB};
        nibs     = '{4'h5, 4'h5, 4'h5, 4'h5, 4'h5, 4'hD};
        strobe   = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        nib_byte = '{8'h00, 8'h55, 8'h00, 8'h55, 8'h00, 8'hD5};

        // Reset state
        rst = 1'b1;
        mii_select = 1'b0;
        step(5'h00, 5'h00);
        step(5'h00, 5'h00);
        chk("reset_outputs", all_out(), 32'h0);
        rst = 1'b0;

        // In-band status filter: two matching samples needed
        step(IDLE_W, IDLE_W);
        chk("status_first_sample_valid", 32'(status_valid), 32'h0);
        chk("status_first_sample_clk_en", 32'(gmii_clk_en), 32'h1);
        step(IDLE_W, IDLE_W);
        chk("status_accept", 32'({link_up, link_speed, full_duplex, status_valid}), 32'b1_01_1_1);
        step(5'b0_0000, 5'b0_0000);
        chk("status_glitch", 32'({link_up, link_speed, full_duplex, status_valid}), 32'b1_01_1_1);
        step(IDLE_W, IDLE_W);
        chk("status_after_glitch", 32'({link_up, link_speed, full_duplex, status_valid}), 32'b1_01_1_1);

        // 1000 mode frame
        for (int i = 0; i < 4; i++) begin
            logic [7:0] b;
            b = bytes_1g[i];
            step({1'b1, b[3:0]}, {1'b1, b[7:4]});
            chk($sformatf("byte1g_%0d", i),
                32'({gmii_rxd, gmii_rx_dv, gmii_rx_er, gmii_clk_en}), 32'({b, 3'b101}));
        end
        step(IDLE_W, IDLE_W);
        chk("byte1g_end", 32'({gmii_rx_dv, gmii_rx_er, gmii_clk_en}), 32'b001);

        // 1000 mode error, then carrier extend
        step(5'b1_0001, 5'b0_0010);
        chk("err1g_rxer", 32'({gmii_rxd, gmii_rx_dv, gmii_rx_er}), 32'({8'h21, 2'b11}));
        step(5'b0_1111, 5'b1_1111);
        chk("extend_out", 32'({gmii_rx_dv, gmii_rx_er, gmii_clk_en}), 32'b011);
        chk("extend_state", 32'(dut.state_q), 32'(BYTE));
        chk("extend_status", 32'({link_up, link_speed, full_duplex}), 32'b1_01_1);
        step(IDLE_W, IDLE_W);
        chk("extend_end_state", 32'(dut.state_q), 32'(IDLE));
        chk("extend_end_out", 32'({gmii_rx_dv, gmii_rx_er}), 32'b00);

        // Switch to 10/100 mode in IDLE
        mii_select = 1'b1;
        step(IDLE_W, IDLE_W);
        step(IDLE_W, IDLE_W);
        chk("mii_idle_clk_en", 32'(gmii_clk_en), 32'h0);

        // 10/100 frame: 5,5,5,5,5,D
        for (int i = 0; i < 6; i++) begin
            step({1'b1, nibs[i]}, {1'b1, nibs[i]});
            if (strobe[i]) begin
                chk($sformatf("nib_strobe_%0d", i),
                    32'({gmii_rxd, gmii_rx_dv, gmii_rx_er, gmii_clk_en, nibble_misalign}),
                    32'({nib_byte[i], 4'b1010}));
            end else begin
                chk($sformatf("nib_gap_%0d", i), 32'({gmii_clk_en, nibble_misalign}), 32'b00);
            end
        end
        step(IDLE_W, IDLE_W);
        chk("nib_end", 32'({gmii_rx_dv, gmii_rx_er, gmii_clk_en, nibble_misalign}), 32'b0000);

        // 10/100 odd nibble count: A,B,C
        step(5'b1_1010, 5'b1_1010);
        chk("odd_gap0", 32'(gmii_clk_en), 32'h0);
        step(5'b1_1011, 5'b1_1011);
        chk("odd_byte", 32'({gmii_rxd, gmii_rx_dv, gmii_rx_er, gmii_clk_en, nibble_misalign}),
            32'({8'hBA, 4'b1010}));
        step(5'b1_1100, 5'b1_1100);
        chk("odd_gap1", 32'(gmii_clk_en), 32'h0);
        step(IDLE_W, IDLE_W);
        chk("odd_flush", 32'({gmii_rxd, gmii_rx_dv, gmii_rx_er, gmii_clk_en, nibble_misalign}),
            32'({8'h0C, 4'b1111}));
        step(IDLE_W, IDLE_W);
        chk("odd_after", 32'({gmii_clk_en, nibble_misalign}), 32'b00);

        // Mode toggle mid-frame has no effect until IDLE
        step(5'b1_0001, 5'b1_0001);
        mii_select = 1'b0;
        step(5'b1_0010, 5'b1_0010);
        chk("toggle_byte0", 32'({gmii_rxd, gmii_clk_en}), 32'({8'h21, 1'b1}));
        step(5'b1_0011, 5'b1_0011);
        chk("toggle_gap", 32'(gmii_clk_en), 32'h0);
        step(5'b1_0100, 5'b1_0100);
        chk("toggle_byte1", 32'({gmii_rxd, gmii_clk_en}), 32'({8'h43, 1'b1}));
        step(IDLE_W, IDLE_W);
        chk("toggle_end", 32'({gmii_rx_dv, gmii_clk_en}), 32'b00);
        step(IDLE_W, IDLE_W);
        chk("toggle_idle_still_mii", 32'(gmii_clk_en), 32'h0);
        step(IDLE_W, IDLE_W);
        chk("toggle_now_1g", 32'(gmii_clk_en), 32'h1);

        // Reset mid-frame in 10/100 mode
        mii_select = 1'b1;
        step(IDLE_W, IDLE_W);
        step(IDLE_W, IDLE_W);
        step(5'b1_0110, 5'b1_0110);
        step(5'b1_0111, 5'b1_0111);
        chk("prerst_byte", 32'({gmii_rxd, gmii_clk_en}), 32'({8'h76, 1'b1}));
        rst = 1'b1;
        step(5'b1_1000, 5'b1_1000);
        chk("midframe_reset", all_out(), 32'h0);
        rst = 1'b0;
        step(IDLE_W, IDLE_W);
        chk("postrst_filter_cleared", 32'({link_up, status_valid}), 32'b00);
        chk("postrst_state", 32'(dut.state_q), 32'(IDLE));
        step(IDLE_W, IDLE_W);
        chk("postrst_status", 32'({link_up, link_speed, full_duplex, status_valid}), 32'b1_01_1_1);
        chk("postrst_mii_mode", 32'(gmii_clk_en), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
